gradient_mag_dir: RTL and testbench

GRADIENT_MAG_DIR -- requirements
Module: gradient_mag_dir

---
 rtl/gradient_pkg.sv | 46 ++++
 rtl/gradient_mag_dir_frame_tracker.sv | 101 ++++++++++
 rtl/gradient_mag_dir.sv | 165 ++++++++++++++++
 tb/tb_gradient_mag_dir.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gradient_pkg.sv
// Shared types, field widths and the direction quantizer for the gradient
// magnitude/direction pipeline.
package gradient_pkg;

  // Width of each signed gradient field packed into the 32-bit input word.
  localparam int GX_GY_FIELD_W = 16;
  // |G| needs one extra bit so that |-32768| = 32768 is representable.
  localparam int ABS_W         = GX_GY_FIELD_W + 1;
  // |Gx| + |Gy| needs one more bit again.
  localparam int RAW_W         = ABS_W + 1;
  // 5 * |G| needs three more bits than |G| to be overflow-free.
  localparam int PROD_W        = ABS_W + 3;

  typedef enum logic [1:0] {
    DIR_0   = 2'd0,
    DIR_45  = 2'd1,
    DIR_90  = 2'd2,
    DIR_135 = 2'd3
  } dir_t;

  typedef enum logic {
    ST_WAIT_SOF = 1'b0,
    ST_IN_FRAME = 1'b1
  } frame_state_t;

  // Quantize the gradient angle into four bins using integer tangent
  // thresholds (tan 22.5deg ~ 2/5, tan 67.5deg ~ 5/2). Gx = Gy = 0 lands in
  // DIR_0 because 0 <= 0 satisfies the first test.
  function automatic dir_t quantize_dir(input logic [ABS_W-1:0] ax,
                                        input logic [ABS_W-1:0] ay,
                                        input logic             same_sign);
    logic [PROD_W-1:0] ax2;
    logic [PROD_W-1:0] ax5;
    logic [PROD_W-1:0] ay2;
    logic [PROD_W-1:0] ay5;
    ax2 = PROD_W'(ax) << 1;
    ay2 = PROD_W'(ay) << 1;
    ax5 = (PROD_W'(ax) << 2) + PROD_W'(ax);
    ay5 = (PROD_W'(ay) << 2) + PROD_W'(ay);
    if (ay5 <= ax2)      return DIR_0;
    else if (ay2 >= ax5) return DIR_90;
    else if (same_sign)  return DIR_45;
    else                 return DIR_135;
  endfunction

endpackage

// File: rtl/gradient_mag_dir_frame_tracker.sv
// Frame tracker: follows the sof / column / row position of incoming beats,
// drops beats that arrive outside a frame and flags framing violations.
// Its flag outputs are registered and form pipeline stage 1 of the flags.
module frame_tracker
  import gradient_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic i_clk,
  input  logic i_aresetn,
  input  logic i_valid,
  input  logic i_sof,
  output logic o_valid,
  output logic o_sof,
  output logic o_eol,
  output logic o_eof,
  output logic o_error
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH  - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  frame_state_t     r_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_valid;
  logic             r_sof;
  logic             r_eol;
  logic             r_eof;
  logic             r_error;

  logic [COL_W-1:0] w_cur_col;
  logic [ROW_W-1:0] w_cur_row;
  logic [COL_W-1:0] w_next_col;
  logic [ROW_W-1:0] w_next_row;
  logic             w_eol;
  logic             w_eof;
  logic             w_accept;
  logic             w_error;

  // A sof beat is always position (0,0) of a fresh frame, whatever the
  // counters say, so a restart mid-frame needs no special casing.
  assign w_cur_col  = i_sof ? '0 : r_col;
  assign w_cur_row  = i_sof ? '0 : r_row;
  assign w_eol      = (w_cur_col == COL_LAST);
  assign w_eof      = w_eol && (w_cur_row == ROW_LAST);
  assign w_next_col = w_eol ? '0 : w_cur_col + COL_W'(1);
  assign w_next_row = w_eof ? '0 : (w_eol ? w_cur_row + ROW_W'(1) : w_cur_row);

  assign w_accept = i_valid && (i_sof || (r_state == ST_IN_FRAME));
  // Violations: data with no frame open, or a new sof while one is open.
  assign w_error  = i_valid && ((!i_sof && (r_state == ST_WAIT_SOF)) ||
                                ( i_sof && (r_state == ST_IN_FRAME)));

  // Frame FSM, position counters and registered per-beat flags.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state <= ST_WAIT_SOF;
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_valid <= w_accept;
      r_sof   <= w_accept && i_sof;
      r_eol   <= w_accept && w_eol;
      r_eof   <= w_accept && w_eof;
      r_error <= w_error;
      case (r_state)
        ST_WAIT_SOF: begin
          if (i_valid && i_sof) begin
            r_col   <= w_next_col;
            r_row   <= w_next_row;
            r_state <= w_eof ? ST_WAIT_SOF : ST_IN_FRAME;
          end
        end
        ST_IN_FRAME: begin
          if (i_valid) begin
            r_col   <= w_next_col;
            r_row   <= w_next_row;
            r_state <= w_eof ? ST_WAIT_SOF : ST_IN_FRAME;
          end
        end
        default: r_state <= ST_WAIT_SOF;
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_sof   = r_sof;
  assign o_eol   = r_eol;
  assign o_eof   = r_eof;
  assign o_error = r_error;

endmodule

// File: rtl/gradient_mag_dir.sv
// Gradient magnitude and quantized direction from packed Gx/Gy beats.
// Three register stages: capture, absolute value, magnitude/direction.
// Frame flags ride alongside the data so every output stays beat-aligned.
module gradient_mag_dir
  import gradient_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int MAG_SHIFT  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic [31:0]           i_Gx_Gy_vector,
  input  logic                  i_data_valid,
  input  logic                  i_start_of_frame,
  output logic [DATA_WIDTH-1:0] o_magnitude,
  output logic [1:0]            o_direction,
  output logic                  o_data_valid,
  output logic                  o_start_of_frame,
  output logic                  o_end_of_line,
  output logic                  o_end_of_frame,
  output logic                  o_frame_error
);

  localparam int F = GX_GY_FIELD_W;
  // Saturation ceiling held in 32 bits so the compare works for any
  // DATA_WIDTH up to 32.
  localparam logic [31:0] MAG_MAX = 32'((64'd1 << DATA_WIDTH) - 64'd1);

  // ---------------- stage 1: capture ----------------
  logic [ABS_W-1:0] r_s1_gx;
  logic [ABS_W-1:0] r_s1_gy;
  logic             w_s1_valid;
  logic             w_s1_sof;
  logic             w_s1_eol;
  logic             w_s1_eof;
  logic             w_s1_err;

  // Sign-extend both fields on capture; hold between beats.
  // NOTE: datapath registers are reset too, because reset must leave every
  // pipeline register and output at a known zero, not just the control bits.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_s1_gx <= '0;
      r_s1_gy <= '0;
    end else if (i_data_valid) begin
      r_s1_gx <= {i_Gx_Gy_vector[F-1],   i_Gx_Gy_vector[F-1:0]};
      r_s1_gy <= {i_Gx_Gy_vector[2*F-1], i_Gx_Gy_vector[2*F-1:F]};
    end
  end

  frame_tracker #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_frame_tracker (
    .i_clk     (i_clk),
    .i_aresetn (i_aresetn),
    .i_valid   (i_data_valid),
    .i_sof     (i_start_of_frame),
    .o_valid   (w_s1_valid),
    .o_sof     (w_s1_sof),
    .o_eol     (w_s1_eol),
    .o_eof     (w_s1_eof),
    .o_error   (w_s1_err)
  );

  // ---------------- stage 2: absolute values ----------------
  logic [ABS_W-1:0] w_abs_gx;
  logic [ABS_W-1:0] w_abs_gy;
  logic [ABS_W-1:0] r_s2_ax;
  logic [ABS_W-1:0] r_s2_ay;
  logic             r_s2_sx;
  logic             r_s2_sy;
  logic             r_s2_valid;
  logic             r_s2_sof;
  logic             r_s2_eol;
  logic             r_s2_eof;
  logic             r_s2_err;

  // Two's-complement negate; the extra bit keeps |-32768| exact.
  assign w_abs_gx = r_s1_gx[ABS_W-1] ? (~r_s1_gx + ABS_W'(1)) : r_s1_gx;
  assign w_abs_gy = r_s1_gy[ABS_W-1] ? (~r_s1_gy + ABS_W'(1)) : r_s1_gy;

  // Register magnitudes and signs for accepted beats; flags every cycle.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value regardless of block order.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_s2_ax    <= '0;
      r_s2_ay    <= '0;
      r_s2_sx    <= 1'b0;
      r_s2_sy    <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_sof   <= 1'b0;
      r_s2_eol   <= 1'b0;
      r_s2_eof   <= 1'b0;
      r_s2_err   <= 1'b0;
    end else begin
      r_s2_valid <= w_s1_valid;
      r_s2_sof   <= w_s1_sof;
      r_s2_eol   <= w_s1_eol;
      r_s2_eof   <= w_s1_eof;
      r_s2_err   <= w_s1_err;
      if (w_s1_valid) begin
        r_s2_ax <= w_abs_gx;
        r_s2_ay <= w_abs_gy;
        r_s2_sx <= r_s1_gx[ABS_W-1];
        r_s2_sy <= r_s1_gy[ABS_W-1];
      end
    end
  end

  // ---------------- stage 3: magnitude and direction ----------------
  logic [RAW_W-1:0]      w_raw;
  logic [31:0]           w_shr;
  logic [DATA_WIDTH-1:0] w_mag;
  dir_t                  w_dir;

  logic [DATA_WIDTH-1:0] r_mag;
  dir_t                  r_dir;
  logic                  r_valid;
  logic                  r_sof;
  logic                  r_eol;
  logic                  r_eof;
  logic                  r_err;

  // L1 norm, scaled down then clamped to the output range.
  assign w_raw = RAW_W'(r_s2_ax) + RAW_W'(r_s2_ay);
  assign w_shr = 32'(w_raw) >> MAG_SHIFT;
  assign w_mag = (w_shr > MAG_MAX) ? MAG_MAX[DATA_WIDTH-1:0] : w_shr[DATA_WIDTH-1:0];
  assign w_dir = quantize_dir(r_s2_ax, r_s2_ay, r_s2_sx == r_s2_sy);

  // Output register: data holds its last value between valid beats.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_mag   <= '0;
      r_dir   <= DIR_0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= r_s2_valid;
      r_sof   <= r_s2_sof;
      r_eol   <= r_s2_eol;
      r_eof   <= r_s2_eof;
      r_err   <= r_s2_err;
      if (r_s2_valid) begin
        r_mag <= w_mag;
        r_dir <= w_dir;
      end
    end
  end

  assign o_magnitude      = r_mag;
  assign o_direction      = r_dir;
  assign o_data_valid     = r_valid;
  assign o_start_of_frame = r_sof;
  assign o_end_of_line    = r_eol;
  assign o_end_of_frame   = r_eof;
  assign o_frame_error    = r_err;

endmodule

// File: tb/tb_gradient_mag_dir.sv
// Self-checking bench for gradient_mag_dir (4x2 frames, shift 4, 8-bit out).
// Directed table vectors, hand-written framing sequences and a randomized
// run, all compared cycle by cycle against a behavioural model.
module tb_gradient_mag_dir;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int SH = 4;
  localparam int DW = 8;

  logic        clk      = 1'b0;
  logic        aresetn  = 1'b1;
  logic        i_valid  = 1'b0;
  logic        i_sof    = 1'b0;
  logic [31:0] i_vec    = '0;
  logic [DW-1:0] o_mag;
  logic [1:0]  o_dir;
  logic        o_valid;
  logic        o_sof;
  logic        o_eol;
  logic        o_eof;
  logic        o_err;

  always #5 clk = ~clk;

  gradient_mag_dir #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .MAG_SHIFT  (SH)
  ) dut (
    .i_clk            (clk),
    .i_aresetn        (aresetn),
    .i_Gx_Gy_vector   (i_vec),
    .i_data_valid     (i_valid),
    .i_start_of_frame (i_sof),
    .o_magnitude      (o_mag),
    .o_direction      (o_dir),
    .o_data_valid     (o_valid),
    .o_start_of_frame (o_sof),
    .o_end_of_line    (o_eol),
    .o_end_of_frame   (o_eof),
    .o_frame_error    (o_err)
  );

  typedef struct {
    bit valid, sof, eol, eof, err;
    int mag, dir;
  } exp_t;

  typedef struct {
    logic [31:0] vec;
    bit          sof;
    int          mag, dir;
    bit          eol, eof;
  } vec_t;

  exp_t q[$];
  int   held_mag, held_dir;
  bit   m_in_frame;
  int   m_idx;
  int   n_checks, n_pass;
  int   cnt_valid, cnt_sof, cnt_eol, cnt_eof, cnt_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] dut_word();
    return {17'd0, o_valid, o_sof, o_eol, o_eof, o_err, o_dir, o_mag};
  endfunction

  function automatic logic [31:0] exp_word(bit v, bit s, bit l, bit f, bit e, int d, int m);
    return {17'd0, v, s, l, f, e, 2'(d), 8'(m)};
  endfunction

  // Reference pixel arithmetic: L1 magnitude, tangent-threshold direction.
  function automatic void model_pix(input logic [31:0] v, output int mag, output int dir);
    int gx, gy, ax, ay, raw;
    gx  = $signed(v[15:0]);
    gy  = $signed(v[31:16]);
    ax  = (gx < 0) ? -gx : gx;
    ay  = (gy < 0) ? -gy : gy;
    raw = (ax + ay) >>> SH;
    mag = (raw > (2**DW - 1)) ? (2**DW - 1) : raw;
    if (5 * ay <= 2 * ax)       dir = 0;
    else if (2 * ay >= 5 * ax)  dir = 2;
    else if ((gx < 0) == (gy < 0)) dir = 1;
    else                        dir = 3;
  endfunction

  // Framing model: a single beat index within the frame.
  task automatic model_push(input bit v, input bit s, input logic [31:0] vec);
    exp_t e;
    bit   acc;
    e   = '{default: 0};
    acc = 1'b0;
    if (v) begin
      if (s) begin
        e.err = m_in_frame;
        acc   = 1'b1;
        m_idx = 0;
      end else if (!m_in_frame) begin
        e.err = 1'b1;
      end else begin
        acc = 1'b1;
      end
      if (acc) begin
        e.valid = 1'b1;
        e.sof   = s;
        e.eol   = ((m_idx % W) == W - 1);
        e.eof   = (m_idx == W * H - 1);
        model_pix(vec, e.mag, e.dir);
        m_in_frame = !e.eof;
        m_idx++;
      end
    end
    q.push_back(e);
  endtask

  // One clock of stimulus, then compare outputs with the beat 3 cycles back.
  task automatic step(input bit v, input bit s, input logic [31:0] vec);
    exp_t e;
    i_valid = v;
    i_sof   = s;
    i_vec   = vec;
    model_push(v, s, vec);
    @(posedge clk);
    #1;
    cnt_valid += int'(o_valid);
    cnt_sof   += int'(o_sof);
    cnt_eol   += int'(o_eol);
    cnt_eof   += int'(o_eof);
    cnt_err   += int'(o_err);
    if (q.size() == 3) begin
      e = q.pop_front();
      if (e.valid) begin
        held_mag = e.mag;
        held_dir = e.dir;
      end
      check("pipe", dut_word(), exp_word(e.valid, e.sof, e.eol, e.eof, e.err, held_dir, held_mag));
    end else begin
      check("pipe_fill", dut_word(), exp_word(0, 0, 0, 0, 0, held_dir, held_mag));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0);
  endtask

  task automatic clear_counts();
    cnt_valid = 0; cnt_sof = 0; cnt_eol = 0; cnt_eof = 0; cnt_err = 0;
  endtask

  // Assert reset away from a clock edge; outputs must clear immediately.
  task automatic apply_reset();
    i_valid = 1'b0;
    i_sof   = 1'b0;
    aresetn = 1'b0;
    #1;
    check("reset_clear", dut_word(), 32'h0);
    q.delete();
    held_mag   = 0;
    held_dir   = 0;
    m_in_frame = 1'b0;
    m_idx      = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    aresetn = 1'b1;
    check("reset_state", dut_word(), 32'h0);
  endtask

  function automatic logic [31:0] rand_vec();
    int gx, gy;
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1: begin gx = int'($urandom_range(0, 600)) - 300; gy = int'($urandom_range(0, 600)) - 300; end
      2: begin gx = int'($urandom_range(0, 40)) - 20;   gy = int'($urandom_range(0, 4000)) - 2000; end
      default: begin gx = int'($urandom_range(0, 20000)) - 10000; gy = int'($urandom_range(0, 40)) - 20; end
    endcase
    return {16'(gy), 16'(gx)};
  endfunction

  vec_t tbl[10];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clear_counts();

    tbl[0] = '{32'h0000_0064, 1'b1,   6, 0, 1'b0, 1'b0};
    tbl[1] = '{32'hFFCE_FFCE, 1'b0,   6, 1, 1'b0, 1'b0};
    tbl[2] = '{32'hFFCE_0032, 1'b0,   6, 3, 1'b0, 1'b0};
    tbl[3] = '{32'h00C8_0000, 1'b0,  12, 2, 1'b1, 1'b0};
    tbl[4] = '{32'hE21E_1DE2, 1'b0, 255, 3, 1'b0, 1'b0};
    tbl[5] = '{32'h0000_0000, 1'b0,   0, 0, 1'b0, 1'b0};
    tbl[6] = '{32'h8000_8000, 1'b0, 255, 1, 1'b0, 1'b0};
    tbl[7] = '{32'h0028_0064, 1'b0,   8, 0, 1'b1, 1'b1};
    tbl[8] = '{32'h0064_FFD8, 1'b1,   8, 2, 1'b0, 1'b0};
    tbl[9] = '{32'h0064_0029, 1'b0,   8, 1, 1'b0, 1'b0};

    #2;
    apply_reset();

    // Directed vectors, each isolated so its output is checked 3 cycles on.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, tbl[i].sof, tbl[i].vec);
      idle(2);
      check($sformatf("tbl%0d_mag", i), 32'(o_mag), 32'(tbl[i].mag));
      check($sformatf("tbl%0d_dir", i), 32'(o_dir), 32'(tbl[i].dir));
      check($sformatf("tbl%0d_flags", i), {27'd0, o_valid, o_sof, o_eol, o_eof, o_err},
            {27'd0, 1'b1, tbl[i].sof, tbl[i].eol, tbl[i].eof, 1'b0});
    end

    // Full frame with a 2-cycle valid gap after beat 3.
    apply_reset();
    clear_counts();
    step(1'b1, 1'b1, rand_vec());
    step(1'b1, 1'b0, rand_vec());
    step(1'b1, 1'b0, rand_vec());
    idle(2);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, rand_vec());
    idle(3);
    check("gap_valid_cnt", 32'(cnt_valid), 32'd8);
    check("gap_eol_cnt",   32'(cnt_eol),   32'd2);
    check("gap_eof_cnt",   32'(cnt_eof),   32'd1);
    check("gap_err_cnt",   32'(cnt_err),   32'd0);

    // Beat without sof straight after reset is dropped with an error.
    apply_reset();
    clear_counts();
    step(1'b1, 1'b0, 32'h0000_0064);
    idle(3);
    check("nosof_valid_cnt", 32'(cnt_valid), 32'd0);
    check("nosof_err_cnt",   32'(cnt_err),   32'd1);

    // sof on beat 5 restarts the frame; eof lands 8 beats after it.
    clear_counts();
    step(1'b1, 1'b1, rand_vec());
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, rand_vec());
    step(1'b1, 1'b1, rand_vec());
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, rand_vec());
    idle(3);
    check("resof_valid_cnt", 32'(cnt_valid), 32'd12);
    check("resof_sof_cnt",   32'(cnt_sof),   32'd2);
    check("resof_err_cnt",   32'(cnt_err),   32'd1);
    check("resof_eof_cnt",   32'(cnt_eof),   32'd1);

    // Reset with beats in flight, then a non-sof beat must be rejected.
    step(1'b1, 1'b1, 32'h00C8_0000);
    step(1'b1, 1'b0, 32'h0000_0064);
    step(1'b1, 1'b0, 32'hE21E_1DE2);
    apply_reset();
    clear_counts();
    step(1'b1, 1'b0, 32'h0000_0064);
    idle(3);
    check("postrst_valid_cnt", 32'(cnt_valid), 32'd0);
    check("postrst_err_cnt",   32'(cnt_err),   32'd1);

    // Randomized traffic against the model, with one reset mid-run.
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      bit v, s;
      if (k == 300) apply_reset();
      v = ($urandom_range(0, 3) != 0);
      s = m_in_frame ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 9) < 7);
      step(v, s, rand_vec());
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
